// File: rtl/pc_unit.sv
// Program counter with branch/jump/jr/jal/ret next-PC selection and an optional return-address stack.
// Define PC_UNIT_RAS_EN to build the RAS; without it jal acts as jump (link_out still loads) and ret acts as jr.
module pc_unit #(
  parameter int          ADDR_W    = 32,
  parameter int          IMM_W     = 16,
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter int          RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic [2:0]        pc_sel,
  input  logic              branch_taken,
  input  logic [IMM_W-1:0]  imm,
  input  logic [25:0]       jtarget,
  input  logic [ADDR_W-1:0] reg_target,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [ADDR_W-1:0] link_out,
  output logic              addr_err,
  output logic              ras_empty,
  output logic              ras_full
);

  typedef enum logic [2:0] {
    SEL_SEQ    = 3'b000,
    SEL_BRANCH = 3'b001,
    SEL_JUMP   = 3'b010,
    SEL_JR     = 3'b011,
    SEL_JAL    = 3'b100,
    SEL_RET    = 3'b101
  } pc_sel_e;

  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] link_r;
  logic              addr_err_r;

  logic [ADDR_W-1:0] pc_plus4_s;
  logic [ADDR_W-1:0] br_off_s;
  logic [ADDR_W-1:0] jump_tgt_s;
  logic [ADDR_W-1:0] jr_tgt_s;
  logic              jr_misalign_s;
  logic [ADDR_W-1:0] pc_next_s;
  logic              err_next_s;
  logic              link_load_s;
  logic              ras_valid_s;
  logic [ADDR_W-1:0] ras_top_s;

  assign pc_plus4_s    = pc_r + ADDR_W'(32'd4);
  assign br_off_s      = ADDR_W'($signed(imm)) << 2;
  assign jr_tgt_s      = {reg_target[ADDR_W-1:2], 2'b00};
  assign jr_misalign_s = (reg_target[1:0] != 2'b00);

  // Jump target keeps the pc_plus4 region bits above bit 27 (none when ADDR_W is 28)
  always_comb begin
    jump_tgt_s       = pc_plus4_s;
    jump_tgt_s[27:0] = {jtarget, 2'b00};
  end

  // Next-PC, address-error and link-load decode for the current pc_sel
  always_comb begin
    pc_next_s   = pc_plus4_s;
    err_next_s  = 1'b0;
    link_load_s = 1'b0;
    case (pc_sel_e'(pc_sel))
      SEL_SEQ: begin
        pc_next_s = pc_plus4_s;
      end
      SEL_BRANCH: begin
        if (branch_taken) begin
          pc_next_s = pc_plus4_s + br_off_s;
        end else begin
          pc_next_s = pc_plus4_s;
        end
      end
      SEL_JUMP: begin
        pc_next_s = jump_tgt_s;
      end
      SEL_JR: begin
        pc_next_s  = jr_tgt_s;
        err_next_s = jr_misalign_s;
      end
      SEL_JAL: begin
        pc_next_s   = jump_tgt_s;
        link_load_s = 1'b1;
      end
      SEL_RET: begin
        // An empty stack falls back to the register target, exactly like jr
        if (ras_valid_s) begin
          pc_next_s = ras_top_s;
        end else begin
          pc_next_s  = jr_tgt_s;
          err_next_s = jr_misalign_s;
        end
      end
      default: begin
        pc_next_s = pc_plus4_s;
      end
    endcase
  end

  // PC, link and address-error registers; stall holds state and suppresses addr_err
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r       <= RESET_VEC[ADDR_W-1:0];
      link_r     <= {ADDR_W{1'b0}};
      addr_err_r <= 1'b0;
    end else if (stall) begin
      addr_err_r <= 1'b0;
    end else begin
      pc_r       <= pc_next_s;
      addr_err_r <= err_next_s;
      if (link_load_s) begin
        link_r <= pc_plus4_s;
      end
    end
  end

`ifdef PC_UNIT_RAS_EN
  localparam int PTR_W = $clog2(RAS_DEPTH);

  logic [ADDR_W-1:0] ras_mem_r [RAS_DEPTH];
  logic [PTR_W-1:0]  ras_sp_r;
  logic [PTR_W:0]    ras_cnt_r;
  logic              ras_empty_r;
  logic              ras_full_r;
  logic [PTR_W:0]    ras_cnt_next_s;
  logic [PTR_W-1:0]  ras_top_idx_s;
  logic              push_s;
  logic              pop_s;

  assign push_s        = ~stall & (pc_sel == SEL_JAL);
  assign pop_s         = ~stall & (pc_sel == SEL_RET) & ~ras_empty_r;
  assign ras_top_idx_s = ras_sp_r - PTR_W'(1);
  assign ras_top_s     = ras_mem_r[ras_top_idx_s];
  assign ras_valid_s   = ~ras_empty_r;

  // Entry count saturates at RAS_DEPTH: a push when full overwrites the oldest slot
  always_comb begin
    ras_cnt_next_s = ras_cnt_r;
    if (push_s) begin
      if (ras_cnt_r == (PTR_W + 1)'(RAS_DEPTH)) begin
        ras_cnt_next_s = ras_cnt_r;
      end else begin
        ras_cnt_next_s = ras_cnt_r + (PTR_W + 1)'(1);
      end
    end else if (pop_s) begin
      ras_cnt_next_s = ras_cnt_r - (PTR_W + 1)'(1);
    end else begin
      ras_cnt_next_s = ras_cnt_r;
    end
  end

  // Stack pointer, count and registered status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      ras_sp_r    <= {PTR_W{1'b0}};
      ras_cnt_r   <= {(PTR_W + 1){1'b0}};
      ras_empty_r <= 1'b1;
      ras_full_r  <= 1'b0;
    end else begin
      if (push_s) begin
        ras_sp_r <= ras_sp_r + PTR_W'(1);
      end else if (pop_s) begin
        ras_sp_r <= ras_top_idx_s;
      end
      ras_cnt_r   <= ras_cnt_next_s;
      ras_empty_r <= (ras_cnt_next_s == (PTR_W + 1)'(0));
      ras_full_r  <= (ras_cnt_next_s == (PTR_W + 1)'(RAS_DEPTH));
    end
  end

  // Stack storage; contents are invalidated through the count, so no reset is needed
  always_ff @(posedge clk) begin
    if (!rst && push_s) begin
      ras_mem_r[ras_sp_r] <= pc_plus4_s;
    end
  end

  assign ras_empty = ras_empty_r;
  assign ras_full  = ras_full_r;
`else
  assign ras_valid_s = 1'b0;
  assign ras_top_s   = {ADDR_W{1'b0}};
  assign ras_empty   = 1'b1;
  assign ras_full    = 1'b0;
`endif

  assign pc_out   = pc_r;
  assign pc_plus4 = pc_plus4_s;
  assign link_out = link_r;
  assign addr_err = addr_err_r;

endmodule
